// File: rtl/cpu_control_unit.sv
// -----------------------------------------------------------------------------
// cpu_control_unit
//   Fetch/decode/execute sequencer for the 4-bit CPU. It drives the 16x4
//   register memory (address, read/write enables, write data), consumes its
//   combinational read data as opcodes, operands and load data, and holds
//   PC, IR, operand register, accumulator and the C/Z flags.
//
// Ports
//   clk_i          system clock
//   reset_i        synchronous, active-high reset
//   mem_addr_o     address to register memory
//   mem_read_en_o  read enable (data valid in the same cycle)
//   mem_write_en_o write enable (commits at next posedge)
//   mem_data_o     write data to memory
//   mem_data_i     combinational read data from memory
//   in_data_i      external input port, sampled by IN
//   out_data_o     output port, loaded by OUT
//   out_valid_o    one-cycle pulse when out_data_o is updated
//   carry_o        C flag
//   zero_o         Z flag
//
// Optional build macro CTRL_HALT_EN adds:
//   halt_i         hold the sequencer in FETCH without fetching
//   halted_o       high while a fetch is being held off
// -----------------------------------------------------------------------------
module cpu_control_unit #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
`ifdef CTRL_HALT_EN
   input  logic                  halt_i,
   output logic                  halted_o,
`endif
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_read_en_o,
   output logic                  mem_write_en_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_valid_o,
   output logic                  carry_o,
   output logic                  zero_o
);

   typedef enum logic [1:0] {S_FETCH, S_OPERAND, S_EXEC} state_t;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0, OP_XOR = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
      OP_ADD = 4'h4, OP_INC = 4'h5, OP_DEC = 4'h6, OP_SUB = 4'h7,
      OP_JMP = 4'h8, OP_JZ  = 4'h9, OP_JC  = 4'hA, OP_LD  = 4'hB,
      OP_ST  = 4'hC, OP_IN  = 4'hD, OP_OUT = 4'hE, OP_LDI = 4'hF
   } opcode_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_ir;
   logic [DATA_WIDTH-1:0] r_opr;
   logic [DATA_WIDTH-1:0] r_acc;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_valid;
   logic                  r_c;
   logic                  r_z;

   opcode_t               w_op;
   logic                  w_fetch_go;
   logic [DATA_WIDTH-1:0] w_b;
   logic [DATA_WIDTH:0]   w_sum;
   logic [DATA_WIDTH:0]   w_diff;
   logic [DATA_WIDTH-1:0] w_res;
   logic                  w_c_new;
   logic                  w_acc_we;

   function automatic logic has_operand(input opcode_t op);
      case (op)
         OP_XOR, OP_AND, OP_OR, OP_ADD, OP_SUB, OP_JMP, OP_JZ, OP_JC,
         OP_LD, OP_ST, OP_LDI: has_operand = 1'b1;
         default:              has_operand = 1'b0;
      endcase
   endfunction

   assign w_op = opcode_t'(r_ir[3:0]);

`ifdef CTRL_HALT_EN
   assign w_fetch_go = ~halt_i;
   assign halted_o   = (r_state == S_FETCH) && halt_i && !reset_i;
`else
   assign w_fetch_go = 1'b1;
`endif

   // Memory interface: purely a function of the current state so that the
   // read data comes back within the same cycle.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      mem_addr_o     = '0;
      mem_read_en_o  = 1'b0;
      mem_write_en_o = 1'b0;
      mem_data_o     = '0;
      case (r_state)
         S_FETCH: begin
            if (w_fetch_go) begin
               mem_addr_o    = r_pc;
               mem_read_en_o = 1'b1;
            end
         end
         S_OPERAND: begin
            mem_addr_o    = r_pc;
            mem_read_en_o = 1'b1;
         end
         S_EXEC: begin
            case (w_op)
               OP_XOR, OP_AND, OP_OR, OP_ADD, OP_SUB, OP_LD: begin
                  mem_addr_o    = r_opr[ADDR_WIDTH-1:0];
                  mem_read_en_o = 1'b1;
               end
               OP_ST: begin
                  mem_addr_o     = r_opr[ADDR_WIDTH-1:0];
                  mem_write_en_o = 1'b1;
                  mem_data_o     = r_acc;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
      // Reset aborts whatever is in flight, including a pending store.
      if (reset_i) begin
         mem_addr_o     = '0;
         mem_read_en_o  = 1'b0;
         mem_write_en_o = 1'b0;
         mem_data_o     = '0;
      end
   end

   // ALU: the second operand is memory data, or the constant 1 for INC/DEC.
   // The extra top bit of sum/difference is carry out or borrow.
   always_comb begin
      w_b      = (w_op == OP_INC || w_op == OP_DEC) ? DATA_WIDTH'(1) : mem_data_i;
      w_sum    = {1'b0, r_acc} + {1'b0, w_b};
      w_diff   = {1'b0, r_acc} - {1'b0, w_b};
      w_res    = r_acc;
      w_c_new  = r_c;
      w_acc_we = 1'b0;
      case (w_op)
         OP_XOR:         begin w_res = r_acc ^ w_b; w_c_new = 1'b0; w_acc_we = 1'b1; end
         OP_AND:         begin w_res = r_acc & w_b; w_c_new = 1'b0; w_acc_we = 1'b1; end
         OP_OR:          begin w_res = r_acc | w_b; w_c_new = 1'b0; w_acc_we = 1'b1; end
         OP_ADD, OP_INC: begin
            w_res    = w_sum[DATA_WIDTH-1:0];
            w_c_new  = w_sum[DATA_WIDTH];
            w_acc_we = 1'b1;
         end
         OP_SUB, OP_DEC: begin
            w_res    = w_diff[DATA_WIDTH-1:0];
            w_c_new  = w_diff[DATA_WIDTH];
            w_acc_we = 1'b1;
         end
         OP_LD:          begin w_res = w_b;       w_acc_we = 1'b1; end
         OP_LDI:         begin w_res = r_opr;     w_acc_we = 1'b1; end
         OP_IN:          begin w_res = in_data_i; w_acc_we = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      if (reset_i) begin
         r_state     <= S_FETCH;
         r_pc        <= '0;
         r_ir        <= '0;
         r_opr       <= '0;
         r_acc       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_c         <= 1'b0;
         r_z         <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            S_FETCH: begin
               if (w_fetch_go) begin
                  r_ir    <= mem_data_i;
                  r_pc    <= r_pc + ADDR_WIDTH'(1);
                  r_state <= has_operand(opcode_t'(mem_data_i[3:0])) ? S_OPERAND : S_EXEC;
               end
            end
            S_OPERAND: begin
               r_opr   <= mem_data_i;
               r_pc    <= r_pc + ADDR_WIDTH'(1);
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               if (w_acc_we) begin
                  r_acc <= w_res;
                  r_c   <= w_c_new;
                  r_z   <= (w_res == '0);
               end
               case (w_op)
                  OP_JMP: r_pc <= r_opr[ADDR_WIDTH-1:0];
                  OP_JZ:  if (r_z) r_pc <= r_opr[ADDR_WIDTH-1:0];
                  OP_JC:  if (r_c) r_pc <= r_opr[ADDR_WIDTH-1:0];
                  OP_OUT: begin
                     r_out_data  <= r_acc;
                     r_out_valid <= 1'b1;
                  end
                  default: ;
               endcase
               r_state <= S_FETCH;
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

   assign out_data_o  = r_out_data;
   assign out_valid_o = r_out_valid;
   assign carry_o     = r_c;
   assign zero_o      = r_z;

endmodule

// File: tb/tb_cpu_control_unit.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_unit
//   Directed bench for cpu_control_unit. A behavioural 16x4 register memory
//   (combinational read, write at posedge) sits beside the DUT; each program
//   image is copied into it in a single cycle while reset is held.
//   Build with CTRL_HALT_EN defined to include the halt sequence.
// -----------------------------------------------------------------------------
module tb_cpu_control_unit;
   localparam int DW = 4;
   localparam int AW = 4;

   logic          clk_i   = 1'b0;
   logic          reset_i = 1'b1;
   logic [AW-1:0] mem_addr_o;
   logic          mem_read_en_o;
   logic          mem_write_en_o;
   logic [DW-1:0] mem_data_o;
   logic [DW-1:0] mem_data_i;
   logic [DW-1:0] in_data_i = '0;
   logic [DW-1:0] out_data_o;
   logic          out_valid_o;
   logic          carry_o;
   logic          zero_o;
`ifdef CTRL_HALT_EN
   logic          halt_i = 1'b0;
   logic          halted_o;
`endif

   logic [3:0] mem  [16];
   logic [3:0] prog [16];
   logic       ld_en = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   cpu_control_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
`ifdef CTRL_HALT_EN
      .halt_i         (halt_i),
      .halted_o       (halted_o),
`endif
      .mem_addr_o     (mem_addr_o),
      .mem_read_en_o  (mem_read_en_o),
      .mem_write_en_o (mem_write_en_o),
      .mem_data_o     (mem_data_o),
      .mem_data_i     (mem_data_i),
      .in_data_i      (in_data_i),
      .out_data_o     (out_data_o),
      .out_valid_o    (out_valid_o),
      .carry_o        (carry_o),
      .zero_o         (zero_o)
   );

   always @(posedge clk_i) begin
      if (ld_en) mem <= prog;
      else if (mem_write_en_o) mem[mem_addr_o] <= mem_data_o;
   end

   assign mem_data_i = mem[mem_addr_o];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges, landing 1 time unit after the last posedge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // Hold reset, copy prog into memory, leave reset asserted.
   task automatic load_and_reset();
      reset_i = 1'b1;
      ld_en   = 1'b1;
      cyc(1);
      ld_en   = 1'b0;
      cyc(1);
   endtask

   task automatic release_reset();
      reset_i = 1'b0;
      #1;
   endtask

   // Expected OUT values of the default program: 0..15, 15..1, then restart 0, 1.
   function automatic logic [7:0] exp_out(input int k);
      if (k < 16)      exp_out = 8'(k);
      else if (k < 31) exp_out = 8'(31 - k);
      else             exp_out = 8'(k - 31);
   endfunction

   initial begin
      int idx;
      logic prev;

      // ---------------- reset state + default program ----------------
      prog = '{4'hE, 4'h5, 4'hA, 4'h7, 4'h8, 4'h0, 4'hE, 4'h6,
               4'h9, 4'h0, 4'h8, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
      load_and_reset();
      check("rst_read_en",  mem_read_en_o,  1'b0);
      check("rst_write_en", mem_write_en_o, 1'b0);
      check("rst_addr",     mem_addr_o,     4'h0);
      check("rst_wdata",    mem_data_o,     4'h0);
      check("rst_out_data", out_data_o,     4'h0);
      check("rst_out_vld",  out_valid_o,    1'b0);
      check("rst_carry",    carry_o,        1'b0);
      check("rst_zero",     zero_o,         1'b0);
      release_reset();
      check("c0_fetch_en",   mem_read_en_o, 1'b1);
      check("c0_fetch_addr", mem_addr_o,    4'h0);

      idx  = 0;
      prev = 1'b0;
      for (int n = 0; n < 800 && idx < 33; n++) begin
         cyc(1);
         if (out_valid_o) begin
            check("out_seq", out_data_o, exp_out(idx));
            check("out_pulse_1cyc", prev, 1'b0);
            idx++;
         end
         prev = out_valid_o;
      end
      check("out_pulse_count", 8'(idx), 8'd33);

      // ---------------- LDI 9; ST 3; LD 3; ADD 3; OUT ----------------
      prog = '{4'hF, 4'h9, 4'hC, 4'h3, 4'hB, 4'h3, 4'h4, 4'h3,
               4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      load_and_reset();
      release_reset();
      cyc(5);
      check("st_write_en", mem_write_en_o, 1'b1);
      check("st_addr",     mem_addr_o,     4'h3);
      check("st_data",     mem_data_o,     4'h9);
      check("st_read_en",  mem_read_en_o,  1'b0);
      cyc(7);
      check("add_carry", carry_o, 1'b1);
      check("add_zero",  zero_o,  1'b0);
      cyc(2);
      check("add_out_vld", out_valid_o, 1'b1);
      check("add_acc",     out_data_o,  4'h2);

      // ---------------- LDI 5; SUB [D]=5; JZ C (taken) ----------------
      prog = '{4'hF, 4'h5, 4'h7, 4'hD, 4'h9, 4'hC, 4'hE, 4'h0,
               4'h0, 4'h0, 4'h0, 4'h0, 4'hE, 4'h5, 4'h0, 4'h0};
      load_and_reset();
      release_reset();
      cyc(6);
      check("sub_eq_carry", carry_o, 1'b0);
      check("sub_eq_zero",  zero_o,  1'b1);
      cyc(3);
      check("jz_taken_addr", mem_addr_o,    4'hC);
      check("jz_taken_rden", mem_read_en_o, 1'b1);
      cyc(2);
      check("sub_eq_acc", out_data_o, 4'h0);

      // ---------------- LDI 5; SUB [D]=6; JZ C (not taken) ----------------
      prog[13] = 4'h6;
      load_and_reset();
      release_reset();
      cyc(6);
      check("sub_borrow_carry", carry_o, 1'b1);
      check("sub_borrow_zero",  zero_o,  1'b0);
      cyc(3);
      check("jz_fall_addr", mem_addr_o, 4'h6);
      cyc(2);
      check("sub_borrow_acc", out_data_o, 4'hF);

      // ---------------- IN; OUT (2 cycles each) ----------------
      prog = '{4'hD, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
               4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      in_data_i = 4'hA;
      load_and_reset();
      release_reset();
      cyc(2);
      check("in_next_fetch", mem_addr_o,    4'h1);
      check("in_next_rden",  mem_read_en_o, 1'b1);
      check("in_zero",       zero_o,        1'b0);
      cyc(1);
      check("out_exec_vld",  out_valid_o,   1'b0);
      check("out_exec_rden", mem_read_en_o, 1'b0);
      cyc(1);
      check("io_out_vld",    out_valid_o,   1'b1);
      check("io_out_data",   out_data_o,    4'hA);
      check("io_next_fetch", mem_addr_o,    4'h2);
      cyc(1);
      check("io_vld_drop",   out_valid_o,   1'b0);
      in_data_i = 4'h0;

      // ---------------- reset during EXEC of ST ----------------
      prog = '{4'hE, 4'hF, 4'h9, 4'hC, 4'hE, 4'h0, 4'h0, 4'h0,
               4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      load_and_reset();
      release_reset();
      cyc(7);
      check("abort_pre_we", mem_write_en_o, 1'b1);
      reset_i = 1'b1;
      #1;
      check("abort_we",   mem_write_en_o, 1'b0);
      check("abort_addr", mem_addr_o,     4'h0);
      check("abort_data", mem_data_o,     4'h0);
      cyc(1);
      check("abort_mem_e", mem[14],  4'h0);
      check("abort_carry", carry_o,  1'b0);
      check("abort_zero",  zero_o,   1'b0);
      release_reset();
      check("abort_fetch_addr", mem_addr_o,    4'h0);
      check("abort_fetch_rden", mem_read_en_o, 1'b1);
      cyc(2);
      check("abort_acc_vld", out_valid_o, 1'b1);
      check("abort_acc",     out_data_o,  4'h0);

`ifdef CTRL_HALT_EN
      // ---------------- halt for 5 cycles from OPERAND of JC ----------------
      prog = '{4'hE, 4'h5, 4'hA, 4'h7, 4'h8, 4'h0, 4'hE, 4'h6,
               4'h9, 4'h0, 4'h8, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
      load_and_reset();
      release_reset();
      cyc(5);
      halt_i = 1'b1;
      #1;
      check("halt_opr_halted", halted_o,      1'b0);
      check("halt_opr_rden",   mem_read_en_o, 1'b1);
      check("halt_opr_addr",   mem_addr_o,    4'h3);
      cyc(1);
      check("halt_exec_halted", halted_o, 1'b0);
      cyc(1);
      check("halt_held",      halted_o,       1'b1);
      check("halt_held_rden", mem_read_en_o,  1'b0);
      check("halt_held_we",   mem_write_en_o, 1'b0);
      cyc(2);
      check("halt_held_late", halted_o, 1'b1);
      cyc(1);
      halt_i = 1'b0;
      #1;
      check("resume_halted", halted_o,      1'b0);
      check("resume_addr",   mem_addr_o,    4'h4);
      check("resume_rden",   mem_read_en_o, 1'b1);
      cyc(5);
      check("resume_out_vld", out_valid_o, 1'b1);
      check("resume_out",     out_data_o,  4'h1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Fetch/decode/execute sequencer for the 4-bit CPU. It sits directly upstream of the 16x4 register memory and drives that memory's address, read-enable, write-enable and write-data.
- It consumes the memory's combinational read data as opcodes, operands and load data.
- It holds PC, IR, operand register, accumulator (ACC), and C/Z flags, and drives the CPU's output port.

Parameters:
- DATA_WIDTH, 4, width of ACC, IR, operand and memory words.
- ADDR_WIDTH, 4, width of PC and memory address.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  synchronous, active-high reset.
- mem_addr_o  output  ADDR_WIDTH  address to register memory.
- mem_read_en_o  output  1  memory read enable; read data is valid in the same cycle.
- mem_write_en_o  output  1  memory write enable; the write commits at the next posedge.
- mem_data_o  output  DATA_WIDTH  write data to memory.
- mem_data_i  input  DATA_WIDTH  combinational read data from memory.
- in_data_i  input  DATA_WIDTH  external input port, sampled by IN.
- out_data_o  output  DATA_WIDTH  output port, loaded by OUT.
- out_valid_o  output  1  one-cycle pulse when out_data_o is updated.
- carry_o  output  1  C flag.
- zero_o  output  1  Z flag.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (reset_i).
- Reset values: state=FETCH, PC=0, IR=0, OPR=0, ACC=0, C=0, Z=0, out_data_o=0, out_valid_o=0.
- While reset_i=1, mem_read_en_o, mem_write_en_o, mem_addr_o and mem_data_o are forced to 0.
- Opcodes: 0 NOP, 1 XOR, 2 AND, 3 OR, 4 ADD, 5 INC, 6 DEC, 7 SUB, 8 JMP, 9 JZ, A JC, B LD, C ST, D IN, E OUT, F LDI.
- Opcodes with an operand nibble (stored at PC+1): XOR, AND, OR, ADD, SUB, JMP, JZ, JC, LD, ST, LDI.
- FSM states: FETCH, OPERAND, EXEC.
- FETCH: mem_addr_o=PC, read_en=1, IR<=mem_data_i, PC<=PC+1.
  - Next state is OPERAND if the opcode has an operand, else EXEC.
- OPERAND: mem_addr_o=PC, read_en=1, OPR<=mem_data_i, PC<=PC+1, next EXEC.
- EXEC: executes IR, next FETCH.
- Instruction length: 2 cycles without operand, 3 cycles with operand.
- EXEC semantics:
  - XOR/AND/OR/ADD/SUB/LD: mem_addr_o=OPR, read_en=1, B=mem_data_i. ACC <= ACC op B (LD: ACC<=B).
  - LDI: ACC<=OPR.
  - ST: mem_addr_o=OPR, write_en=1, mem_data_o=ACC.
  - INC/DEC: ACC±1.
  - IN: ACC<=in_data_i.
  - OUT: out_data_o<=ACC, out_valid_o<=1 for exactly one cycle.
  - JMP: PC<=OPR. JZ: PC<=OPR if Z=1. JC: PC<=OPR if C=1. Not-taken jumps leave PC unchanged.
  - NOP: no state change.
- Flags:
  - ADD/INC: C = bit 4 of the 5-bit sum.
  - SUB/DEC: C = borrow (ACC < subtrahend).
  - XOR/AND/OR: C cleared.
  - Z = (new ACC == 0) for every ACC-writing instruction.
  - LD/LDI/IN leave C unchanged. Jumps/ST/OUT/NOP leave both flags unchanged.
- Arithmetic is modulo 2^DATA_WIDTH. PC wraps 15->0, including an operand fetch at PC=15.
- Memory enables are 0 in any cycle not listed above.
- Reset asserted mid-instruction aborts it. Any ST write in that cycle is suppressed by the forced-0 enables.

Optional Feature:
- Macro CTRL_HALT_EN.
- Defined: adds input halt_i (1 bit) and output halted_o (1 bit).
  - When halt_i=1 in FETCH: no fetch, PC holds, all memory enables are 0, halted_o=1.
  - An instruction already in OPERAND/EXEC completes before halting.
  - Deasserting halt_i resumes fetch at the held PC on the next cycle.
- Undefined: neither port exists; FETCH always proceeds.

Test Plan:
- Reset, then the default memory program (E,5,A,7,8,0,E,6,9,0,8,6,...):
  - out_valid_o first pulses with out_data_o=0.
  - Subsequent OUT pulses count ACC up 1..15, then down 15..0 (first down pulse value 15, after INC wraps with C=1 and DEC).
  - Then the program restarts at PC=0.
- Write memory with LDI 9; ST 3; LD 3; ADD 3:
  - ST cycle shows write_en=1, addr=3, data=9.
  - After ADD, ACC=2, C=1, Z=0.
- ACC=5, SUB with operand holding 5 -> ACC=0, Z=1, C=0. Then JZ 0xC -> PC=0xC. Same with Z=0 -> PC falls through.
- in_data_i=0xA, IN then OUT -> out_data_o=0xA with a single-cycle out_valid_o pulse. Instruction timing: 2 cycles each.
- Assert reset_i during the EXEC of ST:
  - No write enable is seen.
  - Next cycle: FETCH at PC=0, ACC=0, flags 0.
- With CTRL_HALT_EN, halt_i high for 5 cycles mid-program:
  - Current instruction completes, then halted_o=1 and the PC value is frozen.
  - After release, execution continues identically to an unhalted run.
